matrix_loader: RTL and testbench

Upstream feeder for the 8x8 signed matrix multiplier. Accepts a byte stream over a valid/ready handshake, writes 64 bytes of matrix A into RAM_A and then 64 bytes of matrix B into RAM_B in the column-major layout the multiplier reads (addr = col*8 + row). After the last B byte is written it pulses the multiplier's `start` and waits for its `done`. It also keeps a running signed checksum of all loaded bytes for host-side integrity checks.

---
 rtl/matrix_loader.sv | 146 ++++++++++++++
 tb/tb_matrix_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Byte-stream loader for the 8x8 matrix multiplier: writes A then B column-major,
// starts the multiplier, waits for done, and keeps a signed checksum of the stream.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 8,
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_req,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     mwrA,
  output logic                     mwrB,
  output logic                     mult_start,
  input  logic                     mult_done,
  output logic                     busy,
  output logic                     finished,
  output logic signed [15:0]       checksum
);

  localparam int CNT_W = $clog2(DIM);
  localparam int SUM_W = 16;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_DONE
  } state_t;

  state_t                   state_reg, state_next;
  logic [CNT_W-1:0]         row_reg, row_next;
  logic [CNT_W-1:0]         col_reg, col_next;
  logic signed [SUM_W-1:0]  checksum_reg, checksum_next;
  logic [ADDR_W-1:0]        mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]        mem_data_reg, mem_data_next;
  logic                     mwr_a_reg, mwr_a_next;
  logic                     mwr_b_reg, mwr_b_next;
  logic                     mult_start_reg, mult_start_next;
  logic                     in_ready_reg, in_ready_next;
  logic                     accept;
  logic                     last_beat;

  // in_ready_reg is only ever set in the load states, so it alone qualifies a beat
  assign accept    = in_valid & in_ready_reg;
  assign last_beat = (row_reg == LAST_IDX) && (col_reg == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      checksum_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      mwr_a_reg      <= 1'b0;
      mwr_b_reg      <= 1'b0;
      mult_start_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      col_reg        <= col_next;
      checksum_reg   <= checksum_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
      mwr_a_reg      <= mwr_a_next;
      mwr_b_reg      <= mwr_b_next;
      mult_start_reg <= mult_start_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    col_next        = col_reg;
    checksum_next   = checksum_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    mwr_a_next      = 1'b0;
    mwr_b_next      = 1'b0;
    mult_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_req) begin
          state_next    = LOAD_A;
          row_next      = '0;
          col_next      = '0;
          checksum_next = '0;
        end
      end
      LOAD_A, LOAD_B: begin
        if (accept) begin
          // stream arrives row-major, the multiplier reads column-major
          mem_addr_next = ADDR_W'(col_reg) * ADDR_W'(DIM) + ADDR_W'(row_reg);
          mem_data_next = in_data;
          mwr_a_next    = (state_reg == LOAD_A);
          mwr_b_next    = (state_reg == LOAD_B);
          checksum_next = checksum_reg
                          + {{(SUM_W - DATA_W){in_data[DATA_W-1]}}, in_data};
          if (col_reg == LAST_IDX) begin
            col_next = '0;
            row_next = (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
          end else begin
            col_next = col_reg + 1'b1;
          end
          if (last_beat) begin
            state_next = (state_reg == LOAD_A) ? LOAD_B : START;
          end
        end
      end
      START: begin
        // registered one edge later so the final B write lands before start
        mult_start_next = 1'b1;
        state_next      = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mult_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    in_ready_next = (state_next == LOAD_A) || (state_next == LOAD_B);
  end

  assign in_ready   = in_ready_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign mwrA       = mwr_a_reg;
  assign mwrB       = mwr_b_reg;
  assign mult_start = mult_start_reg;
  assign checksum   = checksum_reg;
  assign busy       = (state_reg != IDLE);
  assign finished   = (state_reg == WAIT_DONE) && mult_done;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: streams full loads, checks RAM writes,
// checksum, start/finish handshakes, load_req masking and async reset abort.
module tb_matrix_loader;

  localparam int LOG = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mwrA;
  logic        mwrB;
  logic        mult_start;
  logic        mult_done = 1'b0;
  logic        busy;
  logic        finished;
  logic signed [15:0] checksum;

  int tests = 0;
  int fails = 0;

  logic [7:0] stim [0:127];

  // write log and RAM model filled by the monitor
  logic [5:0] a_addr [0:LOG-1];
  logic [7:0] a_data [0:LOG-1];
  logic [5:0] b_addr [0:LOG-1];
  logic [7:0] ram_a [0:63];
  logic [7:0] ram_b [0:63];
  int a_cnt = 0, b_cnt = 0, both_cnt = 0, start_cnt = 0, fin_cnt = 0;
  int cyc = 0, last_b_cyc = 0, start_cyc = 0;

  matrix_loader #(.DATA_W(8), .DIM(8), .ADDR_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_req  (load_req),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mwrA      (mwrA),
    .mwrB      (mwrB),
    .mult_start(mult_start),
    .mult_done (mult_done),
    .busy      (busy),
    .finished  (finished),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mwrA) begin
      if (a_cnt < LOG) begin
        a_addr[a_cnt] <= mem_addr;
        a_data[a_cnt] <= mem_data;
      end
      a_cnt <= a_cnt + 1;
      ram_a[mem_addr] <= mem_data;
    end
    if (mwrB) begin
      if (b_cnt < LOG) b_addr[b_cnt] <= mem_addr;
      b_cnt <= b_cnt + 1;
      ram_b[mem_addr] <= mem_data;
      last_b_cyc <= cyc;
    end
    if (mwrA && mwrB) both_cnt <= both_cnt + 1;
    if (mult_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (finished) fin_cnt <= fin_cnt + 1;
  end

  task automatic start_load();
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  // streams stim[lo..hi-1]; returns #1 after the edge accepting the last beat
  task automatic stream(input int lo, input int hi, input bit gaps, output bit ok);
    int i = lo;
    int guard = 0;
    while (i < hi && guard < 1000) begin
      in_data  = stim[i];
      in_valid = 1'b1;
      @(negedge clk);
      guard++;
      if (in_ready) begin
        @(posedge clk); #1;
        i++;
        if (gaps && i < hi) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    ok = (i == hi);
  endtask

  task automatic wait_start(input int base, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (start_cnt > base) ok = 1'b1;
    end
  endtask

  task automatic complete(input int delay, output bit ok);
    int base = fin_cnt;
    int n = 0;
    repeat (delay) @(posedge clk);
    #1 mult_done = 1'b1;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (fin_cnt > base) ok = 1'b1;
    end
    mult_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tests++; if (mem_addr !== 6'd0) begin fails++; $display("FAIL rst_mem_addr got %0d exp 0", mem_addr); end
    tests++; if (mem_data !== 8'd0) begin fails++; $display("FAIL rst_mem_data got %0d exp 0", mem_data); end
    tests++; if ({mwrA, mwrB, mult_start} !== 3'b000) begin fails++; $display("FAIL rst_strobes got %b exp 000", {mwrA, mwrB, mult_start}); end
    tests++; if ({busy, finished} !== 2'b00) begin fails++; $display("FAIL rst_busy_fin got %b exp 00", {busy, finished}); end
    tests++; if (checksum !== 16'sd0) begin fails++; $display("FAIL rst_checksum got %0d exp 0", checksum); end
    reset_n = 1'b1;
    @(negedge clk);
    tests++; if ({busy, in_ready} !== 2'b00) begin fails++; $display("FAIL idle_busy_ready got %b exp 00", {busy, in_ready}); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_identity();
    int abase = a_cnt, bbase = b_cnt, sbase = start_cnt;
    int errs = 0;
    bit ok;
    for (int i = 0; i < 64; i++) begin
      stim[i]      = (i / 8 == i % 8) ? 8'd1 : 8'd0;
      stim[64 + i] = 8'd2;
    end
    start_load();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ident_busy got %b exp 1", busy); end
    stream(0, 128, 1'b0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ident_stream got timeout exp 128 beats"); end
    @(negedge clk);
    tests++; if (checksum !== 16'sd136) begin fails++; $display("FAIL ident_checksum got %0d exp 136", checksum); end
    wait_start(sbase, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ident_start got timeout exp pulse"); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (a_addr[abase + 1] !== 6'd8) begin fails++; $display("FAIL ident_beat1_addr got %0d exp 8", a_addr[abase + 1]); end
    tests++; if (a_addr[abase + 8] !== 6'd1) begin fails++; $display("FAIL ident_beat8_addr got %0d exp 1", a_addr[abase + 8]); end
    tests++; if (a_addr[abase + 63] !== 6'd63) begin fails++; $display("FAIL ident_beat63_addr got %0d exp 63", a_addr[abase + 63]); end
    tests++; if (b_addr[bbase] !== 6'd0) begin fails++; $display("FAIL ident_beat64_addr got %0d exp 0", b_addr[bbase]); end
    tests++; if ((a_cnt - abase) != 64 || (b_cnt - bbase) != 64) begin fails++; $display("FAIL ident_counts got a=%0d b=%0d exp 64/64", a_cnt - abase, b_cnt - bbase); end
    tests++; if ((start_cnt - sbase) != 1) begin fails++; $display("FAIL ident_start_cnt got %0d exp 1", start_cnt - sbase); end
    tests++; if ((start_cyc - last_b_cyc) != 1) begin fails++; $display("FAIL ident_start_lag got %0d exp 1", start_cyc - last_b_cyc); end
    for (int i = 0; i < 64; i++)
      if (a_addr[abase + i] !== 6'((i % 8) * 8 + i / 8) || b_addr[bbase + i] !== 6'((i % 8) * 8 + i / 8)) errs++;
    tests++; if (errs != 0) begin fails++; $display("FAIL ident_addr_seq got %0d bad exp 0", errs); end
    errs = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (ram_a[c * 8 + r] !== stim[r * 8 + c] || ram_b[c * 8 + r] !== stim[64 + r * 8 + c]) errs++;
    tests++; if (errs != 0) begin fails++; $display("FAIL ident_ram got %0d bad exp 0", errs); end
    complete(5, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ident_finish got timeout exp pulse"); end
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ident_idle_busy got %b exp 0", busy); end
    $display("[TB] test_identity done");
  endtask

  task automatic test_extremes();
    bit ok;
    for (int i = 0; i < 128; i++) stim[i] = 8'h80;
    start_load();
    stream(0, 128, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok || checksum !== -16'sd16384) begin fails++; $display("FAIL min_checksum got %0d exp -16384", checksum); end
    complete(2, ok);
    for (int i = 0; i < 128; i++) stim[i] = 8'h7f;
    start_load();
    stream(0, 128, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok || checksum !== 16'sd16256) begin fails++; $display("FAIL max_checksum got %0d exp 16256", checksum); end
    complete(2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL max_finish got timeout exp pulse"); end
    $display("[TB] test_extremes done");
  endtask

  task automatic test_valid_toggle();
    int abase = a_cnt, bbase = b_cnt, both0 = both_cnt, sbase = start_cnt;
    int errs = 0;
    bit ok;
    for (int i = 0; i < 128; i++) stim[i] = 8'(i * 3);
    start_load();
    stream(0, 128, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL tog_stream got timeout exp 128 beats"); end
    wait_start(sbase, ok);
    tests++; if ((a_cnt - abase) != 64 || (b_cnt - bbase) != 64) begin fails++; $display("FAIL tog_counts got a=%0d b=%0d exp 64/64", a_cnt - abase, b_cnt - bbase); end
    for (int i = 0; i < 64; i++)
      if (a_addr[abase + i] !== 6'((i % 8) * 8 + i / 8) || b_addr[bbase + i] !== 6'((i % 8) * 8 + i / 8)) errs++;
    tests++; if (errs != 0) begin fails++; $display("FAIL tog_addr_seq got %0d bad exp 0", errs); end
    tests++; if (both_cnt != both0) begin fails++; $display("FAIL tog_both_strobes got %0d exp 0", both_cnt - both0); end
    complete(1, ok);
    $display("[TB] test_valid_toggle done");
  endtask

  task automatic test_load_req_ignored();
    int bbase = b_cnt, sbase = start_cnt, fbase = fin_cnt;
    int bad = 0;
    bit ok;
    for (int i = 0; i < 128; i++) stim[i] = 8'hff;
    start_load();
    stream(0, 64, 1'b0, ok);
    load_req = 1'b1;
    stream(64, 128, 1'b0, ok);
    wait_start(sbase, ok);
    tests++; if (!ok || (b_cnt - bbase) != 64) begin fails++; $display("FAIL lreq_b_writes got %0d exp 64", b_cnt - bbase); end
    tests++; if (checksum !== -16'sd128) begin fails++; $display("FAIL lreq_checksum got %0d exp -128", checksum); end
    repeat (19) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL lreq_restart got %0d bad cycles exp 0", bad); end
    @(posedge clk); #1;
    mult_done = 1'b1;
    load_req  = 1'b0;
    @(negedge clk);
    tests++; if ({finished, busy} !== 2'b11) begin fails++; $display("FAIL lreq_finished got %b exp 11", {finished, busy}); end
    @(negedge clk);
    tests++; if ({finished, busy, in_ready} !== 3'b000) begin fails++; $display("FAIL lreq_idle got %b exp 000", {finished, busy, in_ready}); end
    tests++; if ((fin_cnt - fbase) != 1) begin fails++; $display("FAIL lreq_fin_width got %0d exp 1", fin_cnt - fbase); end
    @(posedge clk); #1;
    mult_done = 1'b0;
    $display("[TB] test_load_req_ignored done");
  endtask

  task automatic test_reset_abort();
    int abase;
    bit ok;
    for (int i = 0; i < 128; i++) stim[i] = 8'd3;
    start_load();
    stream(0, 30, 1'b0, ok);
    tests++; if (mwrA !== 1'b1 || checksum !== 16'sd90) begin fails++; $display("FAIL abort_pre got mwrA=%b sum=%0d exp 1/90", mwrA, checksum); end
    reset_n = 1'b0;
    #1;
    tests++; if ({mwrA, mwrB, in_ready, busy, mult_start} !== 5'b0) begin fails++; $display("FAIL abort_async got %b exp 00000", {mwrA, mwrB, in_ready, busy, mult_start}); end
    tests++; if (checksum !== 16'sd0 || mem_addr !== 6'd0 || mem_data !== 8'd0) begin fails++; $display("FAIL abort_regs got sum=%0d addr=%0d data=%0d exp 0", checksum, mem_addr, mem_data); end
    @(negedge clk);
    reset_n = 1'b1;
    stim[0] = 8'd5;
    abase = a_cnt;
    start_load();
    tests++; if (checksum !== 16'sd0) begin fails++; $display("FAIL abort_new_sum got %0d exp 0", checksum); end
    stream(0, 128, 1'b0, ok);
    @(negedge clk);
    tests++; if (!ok || checksum !== 16'sd386) begin fails++; $display("FAIL abort_reload_sum got %0d exp 386", checksum); end
    tests++; if (a_addr[abase] !== 6'd0 || a_data[abase] !== 8'd5) begin fails++; $display("FAIL abort_first_beat got addr=%0d data=%0d exp 0/5", a_addr[abase], a_data[abase]); end
    complete(2, ok);
    $display("[TB] test_reset_abort done");
  endtask

  task automatic test_done_early();
    bit ok;
    for (int i = 0; i < 128; i++) stim[i] = 8'd1;
    start_load();
    stream(0, 100, 1'b0, ok);
    mult_done = 1'b1;
    stream(100, 128, 1'b0, ok);
    @(negedge clk);
    tests++; if ({mwrB, finished, busy, mult_start} !== 4'b1010) begin fails++; $display("FAIL early_start_cycle got %b exp 1010", {mwrB, finished, busy, mult_start}); end
    @(negedge clk);
    tests++; if ({finished, mult_start, busy} !== 3'b111) begin fails++; $display("FAIL early_finished got %b exp 111", {finished, mult_start, busy}); end
    @(negedge clk);
    tests++; if ({finished, busy} !== 2'b00) begin fails++; $display("FAIL early_idle got %b exp 00", {finished, busy}); end
    tests++; if (checksum !== 16'sd128) begin fails++; $display("FAIL early_checksum got %0d exp 128", checksum); end
    @(posedge clk); #1;
    mult_done = 1'b0;
    $display("[TB] test_done_early done");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_valid_toggle();
    test_load_req_ignored();
    test_reset_abort();
    test_done_early();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
